// File: rtl/elevator_shaft_if.sv
// Command/sensor bundle between the elevator core (master) and the shaft plant model (slave).
interface elevator_shaft_if #(
  parameter int TICKS_PER_FLOOR = 8
);
  localparam int POS_W = $clog2(3*TICKS_PER_FLOOR+1);

  logic             up;
  logic             down;
  logic             stop;
  logic             open_door;
  logic             S1;
  logic             S2;
  logic             S3;
  logic             S4;
  logic [POS_W-1:0] pos;
  logic             door_is_open;
  logic             moving;
  logic             fault;
  logic [2:0]       fault_code;

  modport master (
    output up, down, stop, open_door,
    input  S1, S2, S3, S4, pos, door_is_open, moving, fault, fault_code
  );

  modport slave (
    input  up, down, stop, open_door,
    output S1, S2, S3, S4, pos, door_is_open, moving, fault, fault_code
  );
endinterface

// File: rtl/elevator_shaft_model.sv
// Plant model of a 4-floor car: turns motor/door commands into position, floor sensors,
// door state and a sticky first-fault record.
//
// state     | meaning
// IDLE      | car stationary, door closed
// MOVE_UP   | car stepped up on the last edge
// MOVE_DOWN | car stepped down on the last edge
// DOOR_OPEN | door open, door_timer holds or counts down
module elevator_shaft_model #(
  parameter int TICKS_PER_FLOOR = 8,
  parameter int DOOR_TICKS      = 4,
  parameter int START_FLOOR     = 0
) (
  input  logic           clk,
  input  logic           reset,
  elevator_shaft_if.slave bus
);
  localparam int POS_W = $clog2(3*TICKS_PER_FLOOR+1);
  localparam int TMR_W = $clog2(DOOR_TICKS+1);
  localparam logic [POS_W-1:0] TOP_POS   = POS_W'(3*TICKS_PER_FLOOR);
  localparam logic [POS_W-1:0] START_POS = POS_W'(START_FLOOR*TICKS_PER_FLOOR);
  localparam logic [TMR_W-1:0] DOOR_LOAD = TMR_W'(DOOR_TICKS);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [TMR_W-1:0] door_timer_q, door_timer_d;
  logic             moving_q, step;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d, cause;
  logic [3:0]       sense;
  logic             multi, go_up, go_down, at_floor, in_door, in_motion;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pos_q        <= START_POS;
      door_timer_q <= '0;
      moving_q     <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      door_timer_q <= door_timer_d;
      moving_q     <= step;
      fault_q      <= fault_d;
      code_q       <= code_d;
    end
  end

  // Conflicting motor commands collapse to stop; no command is also stop.
  assign multi     = (bus.up & bus.down) | (bus.up & bus.stop) | (bus.down & bus.stop);
  assign go_up     = bus.up & ~multi;
  assign go_down   = bus.down & ~multi;
  assign at_floor  = |sense;
  assign in_door   = (state_q == DOOR_OPEN);
  assign in_motion = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    door_timer_d = door_timer_q;
    step         = 1'b0;
    case (state_q)
      DOOR_OPEN: begin
        if (bus.open_door)
          door_timer_d = DOOR_LOAD;
        else if (door_timer_q == '0)
          state_d = IDLE;
        else
          door_timer_d = door_timer_q - 1'b1;
      end
      default: begin
        if (go_up) begin
          if (pos_q != TOP_POS) begin
            pos_d   = pos_q + 1'b1;
            state_d = MOVE_UP;
            step    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (go_down) begin
          if (pos_q != '0) begin
            pos_d   = pos_q - 1'b1;
            state_d = MOVE_DOWN;
            step    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == IDLE && bus.open_door && at_floor) begin
          state_d      = DOOR_OPEN;
          door_timer_d = DOOR_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Lowest cause code wins; only the first fault since reset is recorded.
  always_comb begin
    if (multi)
      cause = 3'd1;
    else if (go_up && !in_door && pos_q == TOP_POS)
      cause = 3'd2;
    else if (go_down && !in_door && pos_q == '0)
      cause = 3'd3;
    else if (bus.open_door && !in_door && (in_motion || !at_floor || step))
      cause = 3'd4;
    else if (in_door && (bus.up || bus.down))
      cause = 3'd5;
    else
      cause = 3'd0;
    fault_d = fault_q;
    code_d  = code_q;
    if (!fault_q && cause != 3'd0) begin
      fault_d = 1'b1;
      code_d  = cause;
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++)
      sense[n] = (pos_q == POS_W'(n*TICKS_PER_FLOOR));
  end

  assign bus.S1           = sense[0];
  assign bus.S2           = sense[1];
  assign bus.S3           = sense[2];
  assign bus.S4           = sense[3];
  assign bus.pos          = pos_q;
  assign bus.door_is_open = in_door;
  assign bus.moving       = moving_q;
  assign bus.fault        = fault_q;
  assign bus.fault_code   = code_q;
endmodule

// File: tb/tb_elevator_shaft_model.sv
// Directed bench for the shaft plant model with hand-computed expectations.
module tb_elevator_shaft_model;
  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   failures  = 0;

  always #5 clk = ~clk;

  elevator_shaft_if #(.TICKS_PER_FLOOR(8)) bus ();

  elevator_shaft_model #(.TICKS_PER_FLOOR(8), .DOOR_TICKS(4), .START_FLOOR(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic u, input logic d, input logic s, input logic o);
    bus.up = u; bus.down = d; bus.stop = s; bus.open_door = o;
  endtask

  task automatic do_reset();
    cmd(0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_home(input string tag);
    check({tag, "_pos"}, int'(bus.pos), 0);
    check({tag, "_s1"}, int'(bus.S1), 1);
    check({tag, "_s234"}, int'({bus.S2, bus.S3, bus.S4}), 0);
    check({tag, "_door"}, int'(bus.door_is_open), 0);
    check({tag, "_fault"}, int'(bus.fault), 0);
    check({tag, "_code"}, int'(bus.fault_code), 0);
  endtask

  initial begin
    reset = 1'b1;
    cmd(0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    check_home("reset");
    check("reset_moving", int'(bus.moving), 0);

    // up held 8 cycles from floor 1
    cmd(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("up_pos", int'(bus.pos), i);
      check("up_moving", int'(bus.moving), 1);
      check("up_s1", int'(bus.S1), 0);
      check("up_s2", int'(bus.S2), (i == 8) ? 1 : 0);
    end
    cmd(0, 0, 1, 0);
    step();
    check("stop_pos", int'(bus.pos), 8);
    check("stop_moving", int'(bus.moving), 0);
    check("stop_s2", int'(bus.S2), 1);
    check("stop_fault", int'(bus.fault), 0);

    // door: open_door 3 cycles, then 4 ticks of countdown
    cmd(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("door_held", int'(bus.door_is_open), 1);
    end
    cmd(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("door_count", int'(bus.door_is_open), 1);
    end
    step();
    check("door_closed", int'(bus.door_is_open), 0);

    // reload during countdown extends by a full DOOR_TICKS
    cmd(0, 0, 1, 1);
    step();
    check("reopen", int'(bus.door_is_open), 1);
    cmd(0, 0, 1, 0);
    step();
    step();
    cmd(0, 0, 1, 1);
    step();
    cmd(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("reload_count", int'(bus.door_is_open), 1);
    end
    step();
    check("reload_closed", int'(bus.door_is_open), 0);
    check("door_fault", int'(bus.fault), 0);

    // overtravel at top
    do_reset();
    cmd(1, 0, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 24) begin
        check("top_pos", int'(bus.pos), 24);
        check("top_s4", int'(bus.S4), 1);
        check("top_fault_early", int'(bus.fault), 0);
      end
      if (i == 25) begin
        check("top_fault", int'(bus.fault), 1);
        check("top_code", int'(bus.fault_code), 2);
        check("top_hold", int'(bus.pos), 24);
      end
    end
    check("top_final", int'(bus.pos), 24);

    // up+down at floor 3, then down overtravel must not overwrite
    do_reset();
    cmd(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step();
    cmd(0, 0, 1, 0);
    step();
    check("f3_pos", int'(bus.pos), 16);
    check("f3_s3", int'(bus.S3), 1);
    cmd(1, 1, 0, 0);
    step();
    check("multi_pos", int'(bus.pos), 16);
    check("multi_fault", int'(bus.fault), 1);
    check("multi_code", int'(bus.fault_code), 1);
    cmd(0, 1, 0, 0);
    for (int i = 0; i < 17; i++) step();
    check("bottom_pos", int'(bus.pos), 0);
    check("bottom_code", int'(bus.fault_code), 1);

    // open_door while moving between floors
    do_reset();
    cmd(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    check("mv_pos", int'(bus.pos), 5);
    cmd(1, 0, 0, 1);
    step();
    check("mv_door", int'(bus.door_is_open), 0);
    check("mv_code", int'(bus.fault_code), 4);
    check("mv_pos2", int'(bus.pos), 6);

    // up during DOOR_OPEN
    do_reset();
    cmd(0, 0, 0, 1);
    step();
    check("do_open", int'(bus.door_is_open), 1);
    cmd(1, 0, 0, 0);
    step();
    check("do_pos", int'(bus.pos), 0);
    check("do_code", int'(bus.fault_code), 5);
    check("do_door", int'(bus.door_is_open), 1);
    cmd(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    check("do_still_open", int'(bus.door_is_open), 1);
    step();
    check("do_closed", int'(bus.door_is_open), 0);
    check("do_moving", int'(bus.moving), 0);

    // reset mid-shaft with a fault latched
    do_reset();
    cmd(1, 0, 0, 0);
    for (int i = 0; i < 13; i++) step();
    cmd(1, 1, 0, 0);
    step();
    check("r13_pos", int'(bus.pos), 13);
    check("r13_code", int'(bus.fault_code), 1);
    cmd(0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_home("r13");

    // reset with door open and a fault latched
    cmd(0, 0, 0, 1);
    step();
    cmd(0, 1, 0, 1);
    step();
    check("rdoor_open", int'(bus.door_is_open), 1);
    check("rdoor_code", int'(bus.fault_code), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmd(0, 0, 0, 0);
    check_home("rdoor");

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
